mdu_ctrl: RTL and testbench



---
 rtl/mdu_ctrl.sv | 131 +++++++++++++
 tb/tb_mdu_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer: owns HI/LO, holds MULT/DIV for a fixed latency
// and requests a pipeline stall while a HI/LO-dependent instruction must wait.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        md_use,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [2:0] OP_MTHI = 3'd4;
  localparam logic [2:0] OP_MTLO = 3'd5;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [1:0]  op_q;   // bit1 = divide, bit0 = unsigned
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        busy_q;

  logic        is_div;
  logic        is_signed;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] prod;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] den;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;
  logic        div_by_zero;

  assign is_div    = op_q[1];
  assign is_signed = ~op_q[0];

  // Low 64 bits of the product of the extended operands equal the true
  // signed or unsigned 32x32 product, so one multiplier serves both.
  always_comb begin
    a_ext = is_signed ? {{32{a_q[31]}}, a_q} : {32'b0, a_q};
    b_ext = is_signed ? {{32{b_q[31]}}, b_q} : {32'b0, b_q};
    prod  = a_ext * b_ext;
  end

  // Signed divide via magnitudes: quotient truncates toward zero and the
  // remainder takes the dividend's sign. 0x80000000/-1 falls out naturally.
  always_comb begin
    a_neg       = is_signed & a_q[31];
    b_neg       = is_signed & b_q[31];
    mag_a       = a_neg ? (32'd0 - a_q) : a_q;
    mag_b       = b_neg ? (32'd0 - b_q) : b_q;
    div_by_zero = (b_q == 32'd0);
    den         = div_by_zero ? 32'd1 : mag_b;
    q_mag       = mag_a / den;
    r_mag       = mag_a % den;
    quot        = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem         = a_neg ? (32'd0 - r_mag) : r_mag;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      op_q    <= 2'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (md_op[2] == 1'b0) begin
              a_q     <= src_a;
              b_q     <= src_b;
              op_q    <= md_op[1:0];
              cnt_q   <= md_op[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
              busy_q  <= 1'b1;
              state_q <= RUN;
            end else if (md_op == OP_MTHI) begin
              hi_q <= src_a;
            end else if (md_op == OP_MTLO) begin
              lo_q <= src_a;
            end
          end
        end
        RUN: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
            if (!is_div) begin
              hi_q <= prod[63:32];
              lo_q <= prod[31:0];
            end else if (!div_by_zero) begin
              hi_q <= rem;
              lo_q <= quot;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy  = busy_q;
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign stall = md_use & (busy_q | (start & ~md_op[2]));

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: vector table, corner-case sequences and random ops
// checked against a plain-arithmetic HI/LO model.
module tb_mdu_ctrl;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        md_use;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mdu_ctrl #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .md_op (md_op),
    .src_a (src_a),
    .src_b (src_b),
    .md_use(md_use),
    .busy  (busy),
    .stall (stall),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_cyc;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Issue one op from IDLE and count the busy cycles that follow.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, output int n);
    @(negedge clk);
    start = 1'b1; md_op = op; src_a = a; src_b = b;
    #1 chk("busy_on_start_cycle", {63'b0, busy}, 64'd0);
    @(negedge clk);
    start = 1'b0;
    src_a = $urandom; src_b = $urandom;   // operands must not matter during RUN
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
  endtask

  function automatic int model_cycles(input logic [2:0] op);
    if (op <= 3'd1) return MULT_CYCLES;
    if (op <= 3'd3) return DIV_CYCLES;
    return 0;
  endfunction

  function automatic void model_apply(input logic [2:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
    longint x, y, q, r;
    longint unsigned p;
    case (op)
      3'd0: begin
        x = longint'(signed'(a));
        y = longint'(signed'(b));
        q = x * y;
        m_hi = q[63:32];
        m_lo = q[31:0];
      end
      3'd1: begin
        p = {32'b0, a} * {32'b0, b};
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      3'd2: if (b != 32'd0) begin
        x = longint'(signed'(a));
        y = longint'(signed'(b));
        q = x / y;
        r = x % y;
        m_lo = q[31:0];
        m_hi = r[31:0];
      end
      3'd3: if (b != 32'd0) begin
        m_lo = a / b;
        m_hi = a % b;
      end
      3'd4: m_hi = a;
      3'd5: m_lo = a;
      default: ;
    endcase
  endfunction

  initial begin
    int n;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    tbl[0]  = '{3'd0, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
    tbl[1]  = '{3'd1, 32'hFFFF_FFFE, 32'd3,        32'h0000_0002, 32'hFFFF_FFFA, 5};
    tbl[2]  = '{3'd3, 32'd7,         32'd2,        32'd1,         32'd3,         10};
    tbl[3]  = '{3'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    tbl[4]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 10};
    tbl[5]  = '{3'd4, 32'h11,        32'd0,        32'h11,        32'h8000_0000, 0};
    tbl[6]  = '{3'd5, 32'h22,        32'd0,        32'h11,        32'h22,        0};
    tbl[7]  = '{3'd3, 32'h1234_5678, 32'd0,        32'h11,        32'h22,        10};
    tbl[8]  = '{3'd2, 32'd9,         32'd0,        32'h11,        32'h22,        10};
    tbl[9]  = '{3'd6, 32'hDEAD,      32'hBEEF,     32'h11,        32'h22,        0};
    tbl[10] = '{3'd0, 32'd2,         32'd3,        32'd0,         32'd6,         5};
    tbl[11] = '{3'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, 10};

    reset = 1'b1; start = 1'b0; md_op = 3'd0; src_a = 32'd0; src_b = 32'd0; md_use = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {63'b0, busy}, 64'd0);
    chk("reset_hi", {32'b0, hi}, 64'd0);
    chk("reset_lo", {32'b0, lo}, 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, n);
      chk($sformatf("tbl%0d_cycles", i), 64'(n), 64'(tbl[i].exp_cyc));
      chk($sformatf("tbl%0d_hi", i), {32'b0, hi}, {32'b0, tbl[i].exp_hi});
      chk($sformatf("tbl%0d_lo", i), {32'b0, lo}, {32'b0, tbl[i].exp_lo});
    end

    // md_use held through a DIV: stall from the start cycle to the last busy cycle.
    @(negedge clk);
    md_use = 1'b1; start = 1'b1; md_op = 3'd2; src_a = 32'd100; src_b = 32'd7;
    #1 chk("stall_start_cycle", {63'b0, stall}, 64'd1);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      chk("stall_while_busy", {63'b0, stall}, 64'd1);
      n++;
      @(negedge clk);
    end
    chk("stall_div_cycles", 64'(n), 64'(DIV_CYCLES));
    chk("stall_after_busy", {63'b0, stall}, 64'd0);
    chk("div100_7_lo", {32'b0, lo}, 64'd14);
    chk("div100_7_hi", {32'b0, hi}, 64'd2);

    // MTHI in IDLE: no stall, no busy, hi updated the next cycle.
    start = 1'b1; md_op = 3'd4; src_a = 32'h1234;
    #1 chk("mthi_no_stall", {63'b0, stall}, 64'd0);
    @(negedge clk);
    start = 1'b0; md_use = 1'b0;
    chk("mthi_hi", {32'b0, hi}, 64'h1234);
    chk("mthi_busy", {63'b0, busy}, 64'd0);

    // Reset during RUN cycle 3 of a MULT aborts it with no commit.
    start = 1'b1; md_op = 3'd0; src_a = 32'h1234_5678; src_b = 32'h9ABC_DEF0;
    @(negedge clk);
    start = 1'b0;
    chk("abort_busy_run", {63'b0, busy}, 64'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", {63'b0, busy}, 64'd0);
    chk("abort_hi", {32'b0, hi}, 64'd0);
    chk("abort_lo", {32'b0, lo}, 64'd0);
    repeat (6) @(negedge clk);
    chk("abort_no_late_lo", {32'b0, lo}, 64'd0);
    chk("abort_no_late_busy", {63'b0, busy}, 64'd0);
    run_op(3'd0, 32'd2, 32'd3, n);
    chk("post_abort_cycles", 64'(n), 64'(MULT_CYCLES));
    chk("post_abort_lo", {32'b0, lo}, 64'd6);
    chk("post_abort_hi", {32'b0, hi}, 64'd0);

    // start during RUN with other operands must be ignored.
    @(negedge clk);
    start = 1'b1; md_op = 3'd0; src_a = 32'd5; src_b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      start = (n == 2); md_op = 3'd3; src_a = 32'd100; src_b = 32'd3;
      @(negedge clk);
    end
    start = 1'b0;
    chk("ignored_start_cycles", 64'(n), 64'(MULT_CYCLES));
    chk("ignored_start_lo", {32'b0, lo}, 64'd35);
    chk("ignored_start_hi", {32'b0, hi}, 64'd0);
    @(negedge clk);
    chk("ignored_start_idle", {63'b0, busy}, 64'd0);

    // Random ops against the model.
    pulse_reset();
    for (int i = 0; i < 60; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 9));
        default: ;
      endcase
      run_op(rop, ra, rb, n);
      model_apply(rop, ra, rb);
      chk($sformatf("rnd%0d_op%0d_cycles", i, rop), 64'(n), 64'(model_cycles(rop)));
      chk($sformatf("rnd%0d_op%0d_hi a=%h b=%h", i, rop, ra, rb), {32'b0, hi}, {32'b0, m_hi});
      chk($sformatf("rnd%0d_op%0d_lo a=%h b=%h", i, rop, ra, rb), {32'b0, lo}, {32'b0, m_lo});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
